ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_pkg.sv | 25 ++
 rtl/seven_segment.sv | 30 +++
 rtl/ssd_scan_ctrl.sv | 96 +++++++++
 tb/tb_ssd_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller family.
package ssd_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    typedef logic [1:0] digit_sel_t;

    // One complete set of per-display contents: four nibbles, decimal points and blanks.
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } digit_frame_t;

    localparam digit_frame_t FRAME_CLEAR = '{data: 16'h0000, dp: 4'b0000, blank: 4'b0000};
    localparam digit_frame_t FRAME_DARK  = '{data: 16'h0000, dp: 4'b0000, blank: 4'b1111};

    // Active-low one-cold anode pattern selecting a single digit.
    function automatic logic [3:0] anode_for(input digit_sel_t sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/seven_segment.sv
// Combinational hex to active-low seven-segment decoder, bit order {g,f,e,d,c,b,a}.
module seven_segment (
    input  logic [3:0] data,
    output logic [6:0] segment
);

    // Standard hex glyphs, lowercase b and d so they differ from 8 and 0.
    always_comb begin
        segment = 7'b1111111;
        unique case (data)
            4'h0: segment = 7'b1000000;
            4'h1: segment = 7'b1111001;
            4'h2: segment = 7'b0100100;
            4'h3: segment = 7'b0110000;
            4'h4: segment = 7'b0011001;
            4'h5: segment = 7'b0010010;
            4'h6: segment = 7'b0000010;
            4'h7: segment = 7'b1111000;
            4'h8: segment = 7'b0000000;
            4'h9: segment = 7'b0010000;
            4'hA: segment = 7'b0001000;
            4'hB: segment = 7'b0000011;
            4'hC: segment = 7'b1000110;
            4'hD: segment = 7'b0100001;
            4'hE: segment = 7'b0000110;
            4'hF: segment = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous
// double buffering: loads land in staging and only reach the display at a frame
// boundary, so a digit never shows a mix of old and new data mid-scan.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [6:0]  segment,
    output logic        dp,
    output logic [3:0]  anode,
    output logic [1:0]  digit_sel,
    output logic        frame_done,
    output logic        load_pending
);

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic                    tick;
    logic                    frame_boundary;
    digit_frame_t            staging;
    digit_frame_t            display;
    logic [3:0]              cur_nibble;
    logic [6:0]              decoded;

    assign tick           = enable & (&refresh_cnt);
    assign frame_boundary = tick & (digit_sel == 2'd3);
    assign cur_nibble     = display.data[{digit_sel, 2'b00} +: 4];

    seven_segment u_decode (
        .data    (cur_nibble),
        .segment (decoded)
    );

    // Refresh prescaler: free-runs while enabled, holds its value while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            refresh_cnt <= '0;
        else if (enable)
            refresh_cnt <= refresh_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    end

    // Digit scan index advances on each tick; frame_done marks the 3->0 wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_sel  <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_boundary;
            if (tick)
                digit_sel <= digit_sel + 2'd1;
        end
    end

    // Staging captures every load; display takes the old staging only at a boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging      <= FRAME_CLEAR;
            display      <= FRAME_DARK;
            load_pending <= 1'b0;
        end else begin
            if (frame_boundary && load_pending)
                display <= staging;
            if (load) begin
                staging      <= '{data: data_in, dp: dp_in, blank: blank_in};
                load_pending <= 1'b1;
            end else if (frame_boundary) begin
                load_pending <= 1'b0;
            end
        end
    end

    // Registered digit drive so anode, segment and dp switch together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode   <= ANODE_OFF;
            segment <= SEG_BLANK;
            dp      <= 1'b1;
        end else if (!enable || display.blank[digit_sel]) begin
            anode   <= ANODE_OFF;
            segment <= SEG_BLANK;
            dp      <= 1'b1;
        end else begin
            anode   <= anode_for(digit_sel);
            segment <= decoded;
            dp      <= ~display.dp[digit_sel];
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed and randomized bench for ssd_scan_ctrl with a cycle-level
// reference model built from enabled-cycle arithmetic.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  anode;
    logic [1:0]  digit_sel;
    logic        frame_done;
    logic        load_pending;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int          en_count;
    logic        m_pending;
    logic [15:0] m_stg_data, m_disp_data;
    logic [3:0]  m_stg_dp, m_stg_blank, m_disp_dp, m_disp_blank;

    ssd_scan_ctrl #(.REFRESH_BITS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .data_in      (data_in),
        .dp_in        (dp_in),
        .blank_in     (blank_in),
        .segment      (segment),
        .dp           (dp),
        .anode        (anode),
        .digit_sel    (digit_sel),
        .frame_done   (frame_done),
        .load_pending (load_pending)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        en_count     = 0;
        m_pending    = 1'b0;
        m_stg_data   = 16'h0;
        m_stg_dp     = 4'h0;
        m_stg_blank  = 4'h0;
        m_disp_data  = 16'h0;
        m_disp_dp    = 4'h0;
        m_disp_blank = 4'hF;
    endtask

    // One clock of stimulus, model update and full output comparison.
    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] din,
                                 input logic [3:0] dpi, input logic [3:0] bli);
        int         d;
        logic       boundary;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        enable   = en;
        load     = ld;
        data_in  = din;
        dp_in    = dpi;
        blank_in = bli;
        d        = (en_count / 8) % 4;
        boundary = en && (en_count % 32 == 31);
        if (!en || m_disp_blank[d]) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_an    = 4'hF;
            e_an[d] = 1'b0;
            e_seg   = hex_seg(m_disp_data[4*d +: 4]);
            e_dp    = ~m_disp_dp[d];
        end
        if (boundary && m_pending) begin
            m_disp_data  = m_stg_data;
            m_disp_dp    = m_stg_dp;
            m_disp_blank = m_stg_blank;
        end
        if (ld) begin
            m_stg_data  = din;
            m_stg_dp    = dpi;
            m_stg_blank = bli;
            m_pending   = 1'b1;
        end else if (boundary) begin
            m_pending = 1'b0;
        end
        if (en) en_count++;
        @(posedge clk);
        #1;
        checkOutput("anode", 32'(anode), 32'(e_an));
        checkOutput("segment", 32'(segment), 32'(e_seg));
        checkOutput("dp", 32'(dp), 32'(e_dp));
        checkOutput("frame_done", 32'(frame_done), 32'(boundary));
        checkOutput("digit_sel", 32'(digit_sel), 32'((en_count / 8) % 4));
        checkOutput("load_pending", 32'(load_pending), 32'(m_pending));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    initial begin
        // Power-on reset
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        data_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        modelReset();
        #12;
        checkOutput("rst_anode", 32'(anode), 32'h0000000F);
        checkOutput("rst_segment", 32'(segment), 32'h0000007F);
        checkOutput("rst_dp", 32'(dp), 32'h1);
        checkOutput("rst_digit_sel", 32'(digit_sel), 32'h0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
        checkOutput("rst_pending", 32'(load_pending), 32'h0);
        reset = 1'b0;
        $display("[TB] reset released");

        // Dark display with nothing loaded
        idle(10);

        // 1234 with dp on digit 0
        applyStimulus(1'b1, 1'b1, 16'h1234, 4'b0001, 4'b0000);
        idle(70);

        // Two loads in one frame: last one wins
        applyStimulus(1'b1, 1'b1, 16'hAAAA, 4'h0, 4'h0);
        idle(3);
        applyStimulus(1'b1, 1'b1, 16'h5555, 4'h0, 4'h0);
        idle(70);

        // Per-digit blanking of digit 2
        applyStimulus(1'b1, 1'b1, 16'h8888, 4'h0, 4'b0100);
        idle(70);

        // Enable drop while scanning digit 2
        while (((en_count / 8) % 4) != 2) idle(1);
        idle(2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        checkOutput("frozen_digit", 32'(digit_sel), 32'h2);
        idle(20);

        // Load coinciding with a frame boundary while 0000 is pending
        while ((en_count % 32) != 0) idle(1);
        applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0, 4'h0);
        while ((en_count % 32) != 31) idle(1);
        applyStimulus(1'b1, 1'b1, 16'hBEEF, 4'h0, 4'h0);
        checkOutput("pend_after_beef", 32'(load_pending), 32'h1);
        idle(70);

        // Reset mid-scan with a load pending
        applyStimulus(1'b1, 1'b1, 16'h7777, 4'hF, 4'h0);
        idle(3);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_anode", 32'(anode), 32'h0000000F);
        checkOutput("mid_rst_segment", 32'(segment), 32'h0000007F);
        checkOutput("mid_rst_dp", 32'(dp), 32'h1);
        checkOutput("mid_rst_pending", 32'(load_pending), 32'h0);
        modelReset();
        #2 reset = 1'b0;
        idle(40);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic en_r, ld_r;
            en_r = ($urandom_range(0, 9) != 0);
            ld_r = ($urandom_range(0, 19) == 0);
            applyStimulus(en_r, ld_r, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
